// File: rtl/dac8411_receiver_if.sv
// Three-wire DAC8411 serial bus (sclk, syncn, sdin) shared by writer and receiver.
interface dac8411_receiver_if;
  logic sclk;
  logic syncn;
  logic sdin;

  modport master (output sclk, output syncn, output sdin);
  modport slave  (input  sclk, input  syncn, input  sdin);
endinterface

// File: rtl/dac8411_receiver.sv
// DAC8411 serial receiver: oversamples the bus in the clk domain, decodes 24-bit
// frames into PD mode and DAC code, and publishes each completed write.
module dac8411_receiver #(
  parameter int DAC_WIDTH   = 16,
  parameter int FRAME_BITS  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 aresetn,
  dac8411_receiver_if.slave    bus,
  output logic [DAC_WIDTH-1:0] dac_code,
  output logic [1:0]           pd_mode,
  output logic                 code_valid,
  output logic                 frame_error,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_HI = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] syncn_sync_r;
  logic [SYNC_STAGES-1:0] sdin_sync_r;
  logic                   sclk_prev_r;
  logic                   syncn_prev_r;
  logic [SYNC_STAGES:0]   vld_r;

  logic                   sclk_s;
  logic                   syncn_s;
  logic                   sdin_s;
  logic                   sclk_fall_s;
  logic                   syncn_fall_s;
  logic [FRAME_BITS-1:0]  shift_nxt_s;

  state_t                 state_r;
  logic [FRAME_BITS-1:0]  shift_r;
  logic [4:0]             bit_cnt_r;
  logic [DAC_WIDTH-1:0]   dac_code_r;
  logic [1:0]             pd_mode_r;
  logic                   code_valid_r;
  logic                   frame_error_r;
  logic                   busy_r;

  // Input synchronizers, previous-value flops and a fill marker for the chain
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sclk_sync_r  <= {SYNC_STAGES{1'b1}};
      syncn_sync_r <= {SYNC_STAGES{1'b1}};
      sdin_sync_r  <= {SYNC_STAGES{1'b1}};
      sclk_prev_r  <= 1'b1;
      syncn_prev_r <= 1'b1;
      vld_r        <= {(SYNC_STAGES+1){1'b0}};
    end else begin
      sclk_sync_r  <= {sclk_sync_r[SYNC_STAGES-2:0], bus.sclk};
      syncn_sync_r <= {syncn_sync_r[SYNC_STAGES-2:0], bus.syncn};
      sdin_sync_r  <= {sdin_sync_r[SYNC_STAGES-2:0], bus.sdin};
      sclk_prev_r  <= sclk_sync_r[SYNC_STAGES-1];
      syncn_prev_r <= syncn_sync_r[SYNC_STAGES-1];
      vld_r        <= {vld_r[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edge detection and next shift value
  always_comb begin
    sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    syncn_s     = syncn_sync_r[SYNC_STAGES-1];
    sdin_s      = sdin_sync_r[SYNC_STAGES-1];
    sclk_fall_s = ~sclk_s & sclk_prev_r;
    // The reset value 1 in the chain is not a real observation: a syncn held low
    // through reset must not look like a frame start once the chain fills.
    syncn_fall_s = ~syncn_s & syncn_prev_r & vld_r[SYNC_STAGES];
    shift_nxt_s  = {shift_r[FRAME_BITS-2:0], sdin_s};
  end

  // Frame FSM with registered outputs
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r       <= IDLE;
      shift_r       <= {FRAME_BITS{1'b0}};
      bit_cnt_r     <= 5'd0;
      dac_code_r    <= {DAC_WIDTH{1'b0}};
      pd_mode_r     <= 2'b00;
      code_valid_r  <= 1'b0;
      frame_error_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      code_valid_r  <= 1'b0;
      frame_error_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (syncn_fall_s) begin
            state_r   <= SHIFT;
            shift_r   <= {FRAME_BITS{1'b0}};
            bit_cnt_r <= 5'd0;
            busy_r    <= 1'b1;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        SHIFT: begin
          // Abort is judged on the delayed syncn so a rise coinciding with the
          // last sclk edge still commits.
          if (sclk_fall_s && (bit_cnt_r == 5'(FRAME_BITS-1))) begin
            shift_r      <= shift_nxt_s;
            bit_cnt_r    <= bit_cnt_r + 5'd1;
            pd_mode_r    <= shift_nxt_s[FRAME_BITS-1 -: 2];
            dac_code_r   <= shift_nxt_s[FRAME_BITS-3 -: DAC_WIDTH];
            code_valid_r <= 1'b1;
            busy_r       <= 1'b0;
            state_r      <= syncn_s ? IDLE : WAIT_HI;
          end else if (syncn_prev_r) begin
            frame_error_r <= 1'b1;
            busy_r        <= 1'b0;
            state_r       <= IDLE;
          end else if (sclk_fall_s) begin
            shift_r   <= shift_nxt_s;
            bit_cnt_r <= bit_cnt_r + 5'd1;
          end
        end
        WAIT_HI: begin
          busy_r <= 1'b0;
          if (syncn_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign dac_code    = dac_code_r;
  assign pd_mode     = pd_mode_r;
  assign code_valid  = code_valid_r;
  assign frame_error = frame_error_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_dac8411_receiver.sv
// Directed bench for dac8411_receiver: table of frames plus hand sequences for
// reset behaviour and the syncn-rise-on-last-edge case.
module tb_dac8411_receiver;
  localparam int S = 2;

  logic        clk;
  logic        aresetn;
  logic [15:0] dac_code;
  logic [1:0]  pd_mode;
  logic        code_valid;
  logic        frame_error;
  logic        busy;

  dac8411_receiver_if bus_if ();

  dac8411_receiver #(.DAC_WIDTH(16), .FRAME_BITS(24), .SYNC_STAGES(S)) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .bus         (bus_if),
    .dac_code    (dac_code),
    .pd_mode     (pd_mode),
    .code_valid  (code_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int last_valid_cyc = -1;
  int last_err_cyc = -1;

  // Pulse monitor, sampled just after each rising edge
  always begin
    @(posedge clk);
    #1;
    if (code_valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      last_valid_cyc = cyc;
    end
    if (frame_error === 1'b1) begin
      err_cnt = err_cnt + 1;
      last_err_cyc = cyc;
    end
    if (code_valid === 1'b1 && frame_error === 1'b1) both_cnt = both_cnt + 1;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_pulse(input logic bit_v);
    bus_if.sdin = bit_v;
    tick(2);
    bus_if.sclk = 1'b0;
    tick(4);
    bus_if.sclk = 1'b1;
    tick(2);
  endtask

  task automatic run_frame(input logic [1:0] pd, input logic [15:0] data, input int nbits,
                           input bit rise_last, output int vcnt, output int ecnt,
                           output int vcyc, output int ecyc, output int fcyc,
                           output int rcyc, output logic busy_mid);
    logic [23:0] frame;
    int v0;
    int e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    fcyc = -1;
    rcyc = -1;
    busy_mid = 1'b0;
    frame = {pd, data, 6'b000000};
    bus_if.syncn = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      bus_if.sdin = (i < 24) ? frame[23-i] : 1'b1;
      tick(2);
      bus_if.sclk = 1'b0;
      if (i == 23) fcyc = cyc;
      if (rise_last && i == nbits - 1) begin
        bus_if.syncn = 1'b1;
        rcyc = cyc;
      end
      tick(4);
      if (i == 4) busy_mid = busy;
      bus_if.sclk = 1'b1;
      tick(2);
    end
    if (!rise_last) begin
      tick(2);
      bus_if.syncn = 1'b1;
      rcyc = cyc;
    end
    tick(12);
    vcnt = valid_cnt - v0;
    ecnt = err_cnt - e0;
    vcyc = last_valid_cyc;
    ecyc = last_err_cyc;
  endtask

  typedef struct {
    logic [1:0]  pd;
    logic [15:0] data;
    int          nbits;
    int          exp_valid;
    int          exp_err;
    logic [15:0] exp_code;
    logic [1:0]  exp_pd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int vcnt, ecnt, vcyc, ecyc, fcyc, rcyc, v0, e0;
    logic busy_mid;

    vecs[0] = '{2'b00, 16'hAAAA, 24, 1, 0, 16'hAAAA, 2'b00};
    vecs[1] = '{2'b00, 16'h1234, 10, 0, 1, 16'hAAAA, 2'b00};
    vecs[2] = '{2'b11, 16'h00F0, 30, 1, 0, 16'h00F0, 2'b11};
    vecs[3] = '{2'b01, 16'hFFFF, 24, 1, 0, 16'hFFFF, 2'b01};
    vecs[4] = '{2'b10, 16'h0001, 24, 1, 0, 16'h0001, 2'b10};
    vecs[5] = '{2'b00, 16'h8000, 23, 0, 1, 16'h0001, 2'b10};
    vecs[6] = '{2'b00, 16'hAAAA, 24, 1, 0, 16'hAAAA, 2'b00};
    vecs[7] = '{2'b00, 16'h00F0, 24, 1, 0, 16'h00F0, 2'b00};

    // Reset with random bus activity
    aresetn = 1'b0;
    bus_if.sclk = 1'b1;
    bus_if.syncn = 1'b1;
    bus_if.sdin = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus_if.sclk  = 1'($urandom_range(0, 1));
      bus_if.syncn = 1'($urandom_range(0, 1));
      bus_if.sdin  = 1'($urandom_range(0, 1));
    end
    tick(1);
    check("rst_dac_code", 32'(dac_code), 32'h0);
    check("rst_pd_mode", 32'(pd_mode), 32'h0);
    check("rst_code_valid", 32'(code_valid), 32'h0);
    check("rst_frame_error", 32'(frame_error), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    bus_if.sclk = 1'b1;
    bus_if.syncn = 1'b1;
    aresetn = 1'b1;
    tick(10);
    check("post_rst_valid_cnt", 32'(valid_cnt), 32'h0);
    check("post_rst_err_cnt", 32'(err_cnt), 32'h0);
    check("post_rst_busy", 32'(busy), 32'h0);

    // Table of frames
    for (int t = 0; t < 8; t++) begin
      run_frame(vecs[t].pd, vecs[t].data, vecs[t].nbits, 1'b0,
                vcnt, ecnt, vcyc, ecyc, fcyc, rcyc, busy_mid);
      check($sformatf("v%0d_valid_cnt", t), 32'(vcnt), 32'(vecs[t].exp_valid));
      check($sformatf("v%0d_err_cnt", t), 32'(ecnt), 32'(vecs[t].exp_err));
      check($sformatf("v%0d_dac_code", t), 32'(dac_code), 32'(vecs[t].exp_code));
      check($sformatf("v%0d_pd_mode", t), 32'(pd_mode), 32'(vecs[t].exp_pd));
      check($sformatf("v%0d_busy_mid", t), 32'(busy_mid), 32'h1);
      check($sformatf("v%0d_busy_end", t), 32'(busy), 32'h0);
      if (vecs[t].exp_valid != 0)
        check($sformatf("v%0d_valid_cycle", t), 32'(vcyc), 32'(fcyc + 1 + S));
      if (vecs[t].exp_err != 0)
        check($sformatf("v%0d_err_cycle", t), 32'(ecyc), 32'(rcyc + S + 2));
    end

    // syncn rises together with the 24th sclk fall: commit, no error
    run_frame(2'b01, 16'h0F0F, 24, 1'b1, vcnt, ecnt, vcyc, ecyc, fcyc, rcyc, busy_mid);
    check("late_rise_valid_cnt", 32'(vcnt), 32'h1);
    check("late_rise_err_cnt", 32'(ecnt), 32'h0);
    check("late_rise_dac_code", 32'(dac_code), 32'h0F0F);
    check("late_rise_pd_mode", 32'(pd_mode), 32'h1);
    check("late_rise_valid_cycle", 32'(vcyc), 32'(fcyc + 1 + S));
    check("late_rise_busy", 32'(busy), 32'h0);

    // Reset mid-frame after 12 bits, syncn held low throughout
    bus_if.syncn = 1'b0;
    tick(4);
    for (int i = 0; i < 12; i++) sclk_pulse(1'(i % 2));
    check("midrst_busy_before", 32'(busy), 32'h1);
    aresetn = 1'b0;
    tick(3);
    check("midrst_dac_code", 32'(dac_code), 32'h0);
    check("midrst_pd_mode", 32'(pd_mode), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    aresetn = 1'b1;
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 12; i++) sclk_pulse(1'b1);
    tick(6);
    check("midrst_tail_valid_cnt", 32'(valid_cnt - v0), 32'h0);
    check("midrst_tail_err_cnt", 32'(err_cnt - e0), 32'h0);
    check("midrst_tail_busy", 32'(busy), 32'h0);
    check("midrst_tail_dac_code", 32'(dac_code), 32'h0);
    bus_if.syncn = 1'b1;
    tick(4);
    run_frame(2'b00, 16'h5555, 24, 1'b0, vcnt, ecnt, vcyc, ecyc, fcyc, rcyc, busy_mid);
    check("after_rst_valid_cnt", 32'(vcnt), 32'h1);
    check("after_rst_err_cnt", 32'(ecnt), 32'h0);
    check("after_rst_dac_code", 32'(dac_code), 32'h5555);
    check("after_rst_pd_mode", 32'(pd_mode), 32'h0);
    check("after_rst_valid_cycle", 32'(vcyc), 32'(fcyc + 1 + S));

    check("valid_and_error_overlap", 32'(both_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dac8411_receiver.md
# dac8411_receiver

Synthesizable receiver/emulator for the DAC8411 three-wire serial interface (sclk, syncn, sdin). It oversamples the bus in the system clock domain, decodes each 24-bit frame into the power-down mode and the 16-bit DAC code, and publishes each completed write. It closes the loop in the pll_external bench: DAC8411_write output is checked against the code produced by the AD4008 read path. It can also be placed in hardware as a bus monitor.

## Interface
- DAC_WIDTH, 16, data field width; fixed by the frame format.
- FRAME_BITS, 24, total bits per frame: 2 PD + DAC_WIDTH data + 6 don't-care.
- SYNC_STAGES, 2, synchronizer depth on sclk/syncn/sdin; minimum 2.
- clk  in  1  system clock. One clock; all logic on its rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- sclk  in  1  serial clock from the writer; data is sampled on its falling edge.
- syncn  in  1  active-low frame sync.
- sdin  in  1  serial data, MSB first.
- dac_code  out  DAC_WIDTH  last committed data field (frame bits 21..6).
- pd_mode  out  2  last committed PD1:PD0 (frame bits 23..22).
- code_valid  out  1  one-cycle pulse when dac_code/pd_mode update.
- frame_error  out  1  one-cycle pulse when a frame is aborted.
- busy  out  1  high while a frame is being shifted in (state SHIFT).

## Operation
- sclk, syncn and sdin each pass through SYNC_STAGES flops. Reset value of every stage is 1. sdin shares the same delay as sclk, so the sampled bit stays aligned with the edge.
- Falling edges are detected combinationally on the synchronized signals: current 0, previous 1.
- State machine:
  - IDLE -> SHIFT on a syncn falling edge. Clears bit_cnt and the shift register.
  - SHIFT, on each sclk falling edge: shift sdin into the LSB and increment bit_cnt (5 bits).
  - SHIFT, when the edge that makes bit_cnt = FRAME_BITS arrives: commit pd_mode and dac_code from that edge's shift value, pulse code_valid, go to WAIT_HI.
  - SHIFT, syncn rises with bit_cnt < FRAME_BITS: pulse frame_error, no commit, go to IDLE. A partial frame is never committed.
  - WAIT_HI: ignore further sclk edges. syncn high -> IDLE.
- sclk edges in IDLE or WAIT_HI are ignored and do not count.
- An sclk falling edge detected in the same cycle as the syncn falling edge is not counted. Counting starts the cycle after entry to SHIFT.
- If syncn rises in the same cycle as the 24th sclk edge, the frame commits (code_valid, no frame_error) and the FSM goes to IDLE.
- The don't-care bits are shifted but discarded.

## Timing
- Reset values: dac_code = 0, pd_mode = 0, code_valid = 0, frame_error = 0, busy = 0; state IDLE; bit_cnt = 0.
- Reset mid-frame discards the frame. After release with syncn already low, no frame starts until syncn goes high and then falls again.
- Latency: if the first clk edge sampling raw sclk = 0 is edge k, the shift and count update at edge k+SYNC_STAGES. For the 24th bit, dac_code/pd_mode/code_valid change at the same edge.
- frame_error is asserted SYNC_STAGES+1 edges after raw syncn is first sampled high.
- Input constraints:
  - sclk high and low phases each ≥ 2 clk periods.
  - sdin stable ≥ 1 clk period before and after each sclk falling edge.
  - syncn high ≥ 2 clk periods between frames.
  - Violations give undefined decode, but the FSM must still return to IDLE when syncn is high.
- code_valid and frame_error are never high in the same cycle. Each is exactly 1 cycle wide.

## Test plan
- Reset: hold aresetn low with random bus activity -> all outputs 0, busy 0; release -> no pulses until a syncn falling edge.
- Frame PD=00, data 0xAAAA, sclk = clk/8 -> dac_code 0xAAAA, pd_mode 00, single code_valid at the specified edge, busy low afterwards.
- Abort: syncn high after 10 sclk falls of a 0x1234 frame -> frame_error 1 cycle, dac_code stays 0xAAAA, no code_valid.
- Overlong: 30 sclk falls, PD=11, data 0x00F0 -> commit after the 24th edge (0x00F0, pd 11), edges 25-30 ignored, no frame_error.
- Reset mid-frame after 12 bits with syncn held low -> outputs 0. The remaining 12 edges produce no commit. The next full frame 0x5555 commits normally.
- Loopback with DAC8411_write: data_in 0xAAAA, then 0x00F0 -> dac_code tracks each value with pd_mode 00 and one code_valid per write.
